// File: rtl/nx_node_ingress_pkg.sv
// Shared message, command and direction types for the mesh node ingress path.
// Field widths here must match the ingress parameters (ADDR_*_WIDTH, INPUTS, OUTPUTS, INSTR_WIDTH).
package nx_node_ingress_pkg;

    localparam int NX_ROW_W     = 4;
    localparam int NX_COL_W     = 4;
    localparam int NX_SIG_IDX_W = 3;
    localparam int NX_MAP_IDX_W = 3;
    localparam int NX_INSTR_W   = 15;
    localparam int NX_PAYLOAD_W = 15;
    localparam int NX_SIG_W     = NX_SIG_IDX_W + 2;

    typedef enum logic [3:0] {
        NX_CMD_SIG_STATE  = 4'h1,
        NX_CMD_MAP_OUTPUT = 4'h2,
        NX_CMD_LOAD_INSTR = 4'h3
    } nx_command_t;

    typedef enum logic [1:0] {
        NX_DIR_NORTH = 2'd0,
        NX_DIR_EAST  = 2'd1,
        NX_DIR_SOUTH = 2'd2,
        NX_DIR_WEST  = 2'd3
    } nx_direction_t;

    typedef struct packed {
        logic [NX_ROW_W-1:0] row;
        logic [NX_COL_W-1:0] column;
        nx_command_t         command;
    } nx_header_t;

    typedef struct packed {
        nx_header_t              header;
        logic [NX_PAYLOAD_W-1:0] payload;
    } nx_message_t;

    // Signal-state fields occupy the low bits of the payload.
    typedef struct packed {
        logic [NX_SIG_IDX_W-1:0] index;
        logic                    is_seq;
        logic                    state;
    } nx_msg_sig_state_t;

    typedef struct packed {
        logic [NX_MAP_IDX_W-1:0] idx;
        logic [NX_ROW_W-1:0]     tgt_row;
        logic [NX_COL_W-1:0]     tgt_col;
        logic [NX_SIG_IDX_W-1:0] tgt_idx;
        logic                    tgt_seq;
    } nx_msg_map_output_t;

    typedef struct packed {
        logic [NX_INSTR_W-1:0] instr;
    } nx_msg_load_instr_t;

    // Row offset wins over column offset when picking the forwarding direction.
    function automatic nx_direction_t nx_route_dir(
        input logic [NX_ROW_W-1:0] row,
        input logic [NX_COL_W-1:0] col,
        input logic [NX_ROW_W-1:0] node_row,
        input logic [NX_COL_W-1:0] node_col
    );
        nx_direction_t dir;
        if (row < node_row) begin
            dir = NX_DIR_NORTH;
        end else if (row > node_row) begin
            dir = NX_DIR_SOUTH;
        end else if (col < node_col) begin
            dir = NX_DIR_WEST;
        end else begin
            dir = NX_DIR_EAST;
        end
        return dir;
    endfunction

endpackage

// File: rtl/nx_node_ingress_fifo.sv
// Small inbound message buffer with a registered ready flag (ready = not full after this edge).
module nx_node_ingress_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             empty_next_o,
    output logic             ready_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             ready_r;

    // Occupancy after this edge; push is only offered while ready.
    always_comb begin
        count_next_s = count_r;
        if (push_i && !pop_i) begin
            count_next_s = count_r + CNT_W'(1);
        end else if (!push_i && pop_i) begin
            count_next_s = count_r - CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Storage, pointers and ready flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            ready_r  <= 1'b0;
        end else begin
            if (push_i) begin
                mem_r[wr_ptr_r] <= wdata_i;
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != CNT_W'(DEPTH));
        end
    end

    assign rdata_o      = mem_r[rd_ptr_r];
    assign empty_o      = (count_r == CNT_W'(0));
    assign empty_next_o = (count_next_s == CNT_W'(0));
    assign ready_o      = ready_r;

endmodule

// File: rtl/nx_node_ingress.sv
// Inbound decoder for a mesh node: local messages become one-cycle pulses, others are forwarded.
// Optional statistics counters are built when NX_INGRESS_STATS_EN is defined.
module nx_node_ingress
    import nx_node_ingress_pkg::*;
#(
    parameter int ADDR_ROW_WIDTH = 4,
    parameter int ADDR_COL_WIDTH = 4,
    parameter int INPUTS         = 8,
    parameter int OUTPUTS        = 8,
    parameter int INSTR_WIDTH    = 15,
    parameter int BUF_DEPTH      = 2,
    parameter int STAT_WIDTH     = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [ADDR_ROW_WIDTH-1:0]   node_row_i,
    input  logic [ADDR_COL_WIDTH-1:0]   node_col_i,
    input  nx_message_t                 msg_data_i,
    input  logic                        msg_valid_i,
    output logic                        msg_ready_o,
    output nx_message_t                 byp_data_o,
    output nx_direction_t               byp_dir_o,
    output logic                        byp_valid_o,
    input  logic                        byp_ready_i,
    output logic [$clog2(INPUTS)-1:0]   signal_index_o,
    output logic                        signal_is_seq_o,
    output logic                        signal_state_o,
    output logic                        signal_valid_o,
    output logic [$clog2(OUTPUTS)-1:0]  map_idx_o,
    output logic [ADDR_ROW_WIDTH-1:0]   map_tgt_row_o,
    output logic [ADDR_COL_WIDTH-1:0]   map_tgt_col_o,
    output logic [$clog2(INPUTS)-1:0]   map_tgt_idx_o,
    output logic                        map_tgt_seq_o,
    output logic                        map_valid_o,
    output logic [INSTR_WIDTH-1:0]      instr_data_o,
    output logic                        instr_valid_o,
    output logic                        err_o,
    output logic                        idle_o,
    output logic [STAT_WIDTH-1:0]       stat_local_o,
    output logic [STAT_WIDTH-1:0]       stat_byp_o,
    output logic [STAT_WIDTH-1:0]       stat_drop_o
);

    localparam int SIG_IDX_W = $clog2(INPUTS);
    localparam int MAP_IDX_W = $clog2(OUTPUTS);

    nx_message_t        head_s;
    nx_msg_sig_state_t  sig_f_s;
    nx_msg_map_output_t map_f_s;
    logic fifo_empty_s, fifo_empty_next_s, fifo_ready_s;
    logic local_s, pop_s, byp_load_s, byp_valid_next_s;
    logic sig_s, map_s, instr_s, drop_s;

    logic                      signal_valid_r, signal_is_seq_r, signal_state_r;
    logic [SIG_IDX_W-1:0]      signal_index_r;
    logic                      map_valid_r, map_tgt_seq_r;
    logic [MAP_IDX_W-1:0]      map_idx_r;
    logic [ADDR_ROW_WIDTH-1:0] map_tgt_row_r;
    logic [ADDR_COL_WIDTH-1:0] map_tgt_col_r;
    logic [SIG_IDX_W-1:0]      map_tgt_idx_r;
    logic                      instr_valid_r;
    logic [INSTR_WIDTH-1:0]    instr_data_r;
    logic                      err_r, idle_r, byp_valid_r;
    nx_message_t               byp_data_r;
    nx_direction_t             byp_dir_r;

    nx_node_ingress_fifo #(
        .WIDTH ($bits(nx_message_t)),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (msg_valid_i && fifo_ready_s),
        .wdata_i      (msg_data_i),
        .pop_i        (pop_s),
        .rdata_o      (head_s),
        .empty_o      (fifo_empty_s),
        .empty_next_o (fifo_empty_next_s),
        .ready_o      (fifo_ready_s)
    );

    assign sig_f_s = head_s.payload[NX_SIG_W-1:0];
    assign map_f_s = head_s.payload;

    // Head classification; a local head never waits on the bypass slot.
    always_comb begin
        local_s    = (head_s.header.row == node_row_i) && (head_s.header.column == node_col_i);
        pop_s      = !fifo_empty_s && (local_s || !byp_valid_r || byp_ready_i);
        byp_load_s = pop_s && !local_s;
        sig_s      = 1'b0;
        map_s      = 1'b0;
        instr_s    = 1'b0;
        drop_s     = 1'b0;
        if (pop_s && local_s) begin
            case (head_s.header.command)
                NX_CMD_SIG_STATE:  sig_s   = 1'b1;
                NX_CMD_MAP_OUTPUT: map_s   = 1'b1;
                NX_CMD_LOAD_INSTR: instr_s = 1'b1;
                default:           drop_s  = 1'b1;
            endcase
        end else begin
            drop_s = 1'b0;
        end
        if (byp_load_s) begin
            byp_valid_next_s = 1'b1;
        end else if (byp_ready_i) begin
            byp_valid_next_s = 1'b0;
        end else begin
            byp_valid_next_s = byp_valid_r;
        end
    end

    // Local decode: pulses last one cycle, fields hold until the next decode of their kind.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            signal_valid_r  <= 1'b0;
            signal_index_r  <= {SIG_IDX_W{1'b0}};
            signal_is_seq_r <= 1'b0;
            signal_state_r  <= 1'b0;
            map_valid_r     <= 1'b0;
            map_idx_r       <= {MAP_IDX_W{1'b0}};
            map_tgt_row_r   <= {ADDR_ROW_WIDTH{1'b0}};
            map_tgt_col_r   <= {ADDR_COL_WIDTH{1'b0}};
            map_tgt_idx_r   <= {SIG_IDX_W{1'b0}};
            map_tgt_seq_r   <= 1'b0;
            instr_valid_r   <= 1'b0;
            instr_data_r    <= {INSTR_WIDTH{1'b0}};
            err_r           <= 1'b0;
        end else begin
            signal_valid_r <= sig_s;
            map_valid_r    <= map_s;
            instr_valid_r  <= instr_s;
            if (sig_s) begin
                signal_index_r  <= sig_f_s.index;
                signal_is_seq_r <= sig_f_s.is_seq;
                signal_state_r  <= sig_f_s.state;
            end
            if (map_s) begin
                map_idx_r     <= map_f_s.idx;
                map_tgt_row_r <= map_f_s.tgt_row;
                map_tgt_col_r <= map_f_s.tgt_col;
                map_tgt_idx_r <= map_f_s.tgt_idx;
                map_tgt_seq_r <= map_f_s.tgt_seq;
            end
            if (instr_s) begin
                instr_data_r <= head_s.payload;
            end
            if (drop_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Bypass slot: data and direction stay frozen while the downstream stalls.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            byp_valid_r <= 1'b0;
            byp_data_r  <= '0;
            byp_dir_r   <= NX_DIR_NORTH;
            idle_r      <= 1'b0;
        end else begin
            byp_valid_r <= byp_valid_next_s;
            if (byp_load_s) begin
                byp_data_r <= head_s;
                byp_dir_r  <= nx_route_dir(head_s.header.row, head_s.header.column,
                                           node_row_i, node_col_i);
            end
            idle_r <= fifo_empty_next_s && !sig_s && !map_s && !instr_s && !byp_valid_next_s;
        end
    end

`ifdef NX_INGRESS_STATS_EN
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};

    logic [STAT_WIDTH-1:0] stat_local_r, stat_byp_r, stat_drop_r;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (v == STAT_MAX) ? v : v + STAT_WIDTH'(1);
    endfunction

    // Saturating event counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stat_local_r <= {STAT_WIDTH{1'b0}};
            stat_byp_r   <= {STAT_WIDTH{1'b0}};
            stat_drop_r  <= {STAT_WIDTH{1'b0}};
        end else begin
            if (sig_s || map_s || instr_s) begin
                stat_local_r <= sat_inc(stat_local_r);
            end
            if (byp_valid_r && byp_ready_i) begin
                stat_byp_r <= sat_inc(stat_byp_r);
            end
            if (drop_s) begin
                stat_drop_r <= sat_inc(stat_drop_r);
            end
        end
    end

    assign stat_local_o = stat_local_r;
    assign stat_byp_o   = stat_byp_r;
    assign stat_drop_o  = stat_drop_r;
`else
    assign stat_local_o = {STAT_WIDTH{1'b0}};
    assign stat_byp_o   = {STAT_WIDTH{1'b0}};
    assign stat_drop_o  = {STAT_WIDTH{1'b0}};
`endif

    assign msg_ready_o     = fifo_ready_s;
    assign byp_data_o      = byp_data_r;
    assign byp_dir_o       = byp_dir_r;
    assign byp_valid_o     = byp_valid_r;
    assign signal_index_o  = signal_index_r;
    assign signal_is_seq_o = signal_is_seq_r;
    assign signal_state_o  = signal_state_r;
    assign signal_valid_o  = signal_valid_r;
    assign map_idx_o       = map_idx_r;
    assign map_tgt_row_o   = map_tgt_row_r;
    assign map_tgt_col_o   = map_tgt_col_r;
    assign map_tgt_idx_o   = map_tgt_idx_r;
    assign map_tgt_seq_o   = map_tgt_seq_r;
    assign map_valid_o     = map_valid_r;
    assign instr_data_o    = instr_data_r;
    assign instr_valid_o   = instr_valid_r;
    assign err_o           = err_r;
    assign idle_o          = idle_r;

endmodule
